sram512_arbiter: RTL and testbench
==================================

// Module: sram512_arbiter
// PURPOSE
//  - Shares one gf180 512x8 SRAM macro instance between two requesters:
//    port 0 (CPU core) and port 1 (Wishbone host / loader).
//  - Each port uses a req/ack handshake. A 4-state FSM sequences one macro access at a time.
//  - Drives the macro's active-low CEN/GWEN/WEN pins and returns read data to the granted port.
// PARAMETERS
//  - AW   9  address width (512 words)
//  - DW   8  data width
// PORTS
//  - wb_clk_i     in   1   system clock; also drives the macro CLK
//  - wb_rst_i     in   1   synchronous, active-high reset
//  - req0_i/req1_i      in   1   access request; held high until ackN_o
//  - we0_i/we1_i        in   1   1=write, 0=read
//  - addr0_i/addr1_i    in   AW  word address
//  - wdata0_i/wdata1_i  in   DW  write data
//  - wmask0_i/wmask1_i  in   DW  per-bit write enable, active high
//  - ack0_o/ack1_o      out  1   single-cycle completion pulse
//  - rdata0_o/rdata1_o  out  DW  registered read data; valid when ackN_o=1, held otherwise
//  - sram_cen_o   out  1   macro CEN, active low
//  - sram_gwen_o  out  1   macro GWEN, active low
//  - sram_wen_o   out  DW  macro WEN, active low per bit
//  - sram_a_o     out  AW  macro address
//  - sram_d_o     out  DW  macro write data
//  - sram_q_i     in   DW  macro read data
// BEHAVIOUR
//  - Reset values:
//    - state=IDLE; sram_cen_o=1, sram_gwen_o=1, sram_wen_o='1, sram_a_o=0, sram_d_o=0.
//    - ack0_o=ack1_o=0, rdata0_o=rdata1_o=0, last_gnt=1 (so port 0 wins the first tie).
//  - FSM IDLE->ISSUE->CAPT->ACK->IDLE. All outputs are registered.
//  - IDLE: if any req, select grant and latch gnt, we, addr, wdata, wmask; go ISSUE.
//    No req: stay IDLE with CEN=1.
//  - ISSUE: macro pins driven from latched values:
//    - CEN=0, GWEN=~we, WEN = we ? ~wmask : '1, A=addr, D=wdata.
//    - Exactly one cycle; the macro samples on the edge that ends ISSUE.
//  - CAPT: CEN=1, GWEN=1, WEN='1. If read, rdata[gnt] <= sram_q_i at the end of CAPT.
//    Writes leave both rdata regs untouched.
//  - ACK: ack[gnt]=1 for exactly one cycle, the other ack=0; next state IDLE.
//  - Latency: req sampled at edge k -> ack high during cycle k+3. One access per 4 cycles max.
//  - Requester must drop req at the edge ending its ack cycle. Req still high in IDLE is a new access.
//  - Inputs of the granted port are ignored after IDLE latches them; changes mid-access have no effect.
//  - Simultaneous req0/req1 in IDLE: grant by arbitration policy (CONFIGURATION).
//    The loser stays pending and is served at its next IDLE win.
//  - The arbiter never asserts ack0_o and ack1_o in the same cycle.
//  - Never more than one CEN-low cycle per access.
//  - Reset mid-operation (any state):
//    - Next cycle returns to IDLE with reset values; the pending ack is dropped.
//    - A write already issued in ISSUE is not rolled back.
//  - Address wrap: none; AW bits pass straight through.
// CONFIGURATION
//  - SRAM_ARB_RR_EN defined: round-robin arbitration.
//    - Tie -> port != last_gnt; last_gnt updates on every grant.
//    - Each port is guaranteed service within 2 accesses.
//  - SRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties.
//    - Port 1 can starve; last_gnt logic is removed.
// TESTING
//  - Reset: check reset values; no CEN-low cycle until the first req.
//  - Port0 write addr=0x1A5, wdata=0x3C, mask=0xFF; then read 0x1A5.
//    -> ISSUE shows GWEN=0, WEN=0x00; ack0 at k+3; read returns rdata0_o=0x3C.
//  - Bit mask: preload 0x1A5=0xFF; port1 write 0x00 with mask=0x0F.
//    -> WEN=0xF0; subsequent read returns 0xF0.
//  - Tie, RR_EN defined: req0 and req1 held together for 4 accesses.
//    -> grants 0,1,0,1. Undefined: port0 always granted while req0 is held.
//  - Reset asserted in CAPT of a port1 read: ack1_o never pulses, rdata1_o=0.
//    Next req is served normally.
//  - Input change mid-access: port0 read addr=0x010 (mem=0x55); change addr0_i to 0x011 during ISSUE.
//    -> macro A stays 0x010; returns 0x55.

Source files
------------

// File: rtl/sram512_arbiter.sv
// Two-port req/ack arbiter sharing one 512x8 SRAM macro, one access per 4 cycles.
// Define SRAM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module sram512_arbiter #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic          we0_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic [DW-1:0] wdata1_i,
  input  logic [DW-1:0] wmask0_i,
  input  logic [DW-1:0] wmask1_i,
  output logic          ack0_o,
  output logic          ack1_o,
  output logic [DW-1:0] rdata0_o,
  output logic [DW-1:0] rdata1_o,
  output logic          sram_cen_o,
  output logic          sram_gwen_o,
  output logic [DW-1:0] sram_wen_o,
  output logic [AW-1:0] sram_a_o,
  output logic [DW-1:0] sram_d_o,
  input  logic [DW-1:0] sram_q_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, ACK} state_t;

  state_t        state, state_nxt;
  logic          gnt, gnt_nxt;
  logic          we_q, we_nxt;
  logic          ack0_nxt, ack1_nxt;
  logic [DW-1:0] rdata0_nxt, rdata1_nxt;
  logic          cen_nxt, gwen_nxt;
  logic [DW-1:0] wen_nxt, d_nxt;
  logic [AW-1:0] a_nxt;

  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata, sel_wmask;

`ifdef SRAM_ARB_RR_EN
  logic last_gnt, last_gnt_nxt;
`endif

  // Tie-break: pick is the port index granted when a request is present.
  always_comb begin
    pick = req1_i;
    if (req0_i && req1_i) begin
`ifdef SRAM_ARB_RR_EN
      pick = ~last_gnt;
`else
      pick = 1'b0;
`endif
    end
  end

  assign sel_we    = pick ? we1_i    : we0_i;
  assign sel_addr  = pick ? addr1_i  : addr0_i;
  assign sel_wdata = pick ? wdata1_i : wdata0_i;
  assign sel_wmask = pick ? wmask1_i : wmask0_i;

  always_comb begin
    // NOTE: every next-value starts from a hold/default so no path leaves it unassigned (no latches).
    state_nxt  = state;
    gnt_nxt    = gnt;
    we_nxt     = we_q;
    ack0_nxt   = 1'b0;
    ack1_nxt   = 1'b0;
    rdata0_nxt = rdata0_o;
    rdata1_nxt = rdata1_o;
    cen_nxt    = sram_cen_o;
    gwen_nxt   = sram_gwen_o;
    wen_nxt    = sram_wen_o;
    a_nxt      = sram_a_o;
    d_nxt      = sram_d_o;
`ifdef SRAM_ARB_RR_EN
    last_gnt_nxt = last_gnt;
`endif
    unique case (state)
      IDLE: begin
        cen_nxt = 1'b1;
        if (req0_i || req1_i) begin
          // Pins are loaded here so they are already valid throughout ISSUE.
          gnt_nxt   = pick;
          we_nxt    = sel_we;
          cen_nxt   = 1'b0;
          gwen_nxt  = ~sel_we;
          wen_nxt   = sel_we ? ~sel_wmask : '1;
          a_nxt     = sel_addr;
          d_nxt     = sel_wdata;
          state_nxt = ISSUE;
`ifdef SRAM_ARB_RR_EN
          last_gnt_nxt = pick;
`endif
        end
      end
      ISSUE: begin
        cen_nxt   = 1'b1;
        gwen_nxt  = 1'b1;
        wen_nxt   = '1;
        state_nxt = CAPT;
      end
      CAPT: begin
        cen_nxt  = 1'b1;
        gwen_nxt = 1'b1;
        wen_nxt  = '1;
        if (!we_q) begin
          if (gnt) rdata1_nxt = sram_q_i;
          else     rdata0_nxt = sram_q_i;
        end
        ack0_nxt  = ~gnt;
        ack1_nxt  = gnt;
        state_nxt = ACK;
      end
      ACK: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (wb_rst_i) begin
      state       <= IDLE;
      gnt         <= 1'b0;
      we_q        <= 1'b0;
      ack0_o      <= 1'b0;
      ack1_o      <= 1'b0;
      rdata0_o    <= '0;
      rdata1_o    <= '0;
      sram_cen_o  <= 1'b1;
      sram_gwen_o <= 1'b1;
      sram_wen_o  <= '1;
      sram_a_o    <= '0;
      sram_d_o    <= '0;
`ifdef SRAM_ARB_RR_EN
      last_gnt    <= 1'b1;
`endif
    end else begin
      state       <= state_nxt;
      gnt         <= gnt_nxt;
      we_q        <= we_nxt;
      ack0_o      <= ack0_nxt;
      ack1_o      <= ack1_nxt;
      rdata0_o    <= rdata0_nxt;
      rdata1_o    <= rdata1_nxt;
      sram_cen_o  <= cen_nxt;
      sram_gwen_o <= gwen_nxt;
      sram_wen_o  <= wen_nxt;
      sram_a_o    <= a_nxt;
      sram_d_o    <= d_nxt;
`ifdef SRAM_ARB_RR_EN
      last_gnt    <= last_gnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sram512_arbiter.sv
// Self-checking bench for sram512_arbiter: behavioural macro, reference memory, randomized traffic.
module tb_sram512_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [8:0] addr0, addr1;
  logic [7:0] wdata0, wdata1, wmask0, wmask1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
  logic       cen, gwen;
  logic [7:0] wen, d, q;
  logic [8:0] a;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram512_arbiter #(.AW(9), .DW(8)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .wmask0_i(wmask0), .wmask1_i(wmask1),
    .ack0_o(ack0), .ack1_o(ack1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .sram_cen_o(cen), .sram_gwen_o(gwen), .sram_wen_o(wen),
    .sram_a_o(a), .sram_d_o(d), .sram_q_i(q)
  );

  // Behavioural 512x8 macro: samples pins on the rising edge, read data valid after it.
  logic [7:0] sram_mem [512];
  always @(posedge clk) begin
    if (!cen) begin
      if (gwen) q <= sram_mem[a];
      else for (int b = 0; b < 8; b++) if (!wen[b]) sram_mem[a][b] <= d[b];
    end
  end

  // Reference memory: what each address must hold according to the accesses issued so far.
  logic [7:0] ref_mem [512];

  // Pin/ack activity monitor, sampled away from the active edge.
  int         cen_low = 0, ack0_cnt = 0, ack1_cnt = 0, both_cnt = 0;
  logic [8:0] cap_a;
  logic       cap_gwen;
  logic [7:0] cap_wen, cap_d;
  always @(negedge clk) begin
    if (!cen) begin
      cen_low  <= cen_low + 1;
      cap_a    <= a;
      cap_gwen <= gwen;
      cap_wen  <= wen;
      cap_d    <= d;
    end
    if (ack0) ack0_cnt <= ack0_cnt + 1;
    if (ack1) ack1_cnt <= ack1_cnt + 1;
    if (ack0 && ack1) both_cnt <= both_cnt + 1;
  end

  task automatic drive_port(input int port, input logic w, input logic [8:0] ad,
                            input logic [7:0] wd, input logic [7:0] wm, input logic r);
    if (port == 0) begin
      we0 = w; addr0 = ad; wdata0 = wd; wmask0 = wm; req0 = r;
    end else begin
      we1 = w; addr1 = ad; wdata1 = wd; wmask1 = wm; req1 = r;
    end
  endtask

  // One complete access through a single port with full protocol and pin checks.
  task automatic access(input int port, input logic w, input logic [8:0] ad,
                        input logic [7:0] wd, input logic [7:0] wm, input string tag);
    int c0, a0c, a1c, bc, n;
    logic got;
    logic [7:0] rd, exp_wen, exp_rd;
    @(posedge clk);
    c0 = cen_low; a0c = ack0_cnt; a1c = ack1_cnt; bc = both_cnt;
    #1 drive_port(port, w, ad, wd, wm, 1'b1);
    got = 1'b0; rd = '0;
    for (n = 1; n <= 20; n++) begin
      @(negedge clk);
      if ((port == 0) ? ack0 : ack1) begin
        got = 1'b1;
        rd = (port == 0) ? rdata0 : rdata1;
        break;
      end
    end
    @(posedge clk);
    #1 drive_port(port, w, ad, wd, wm, 1'b0);
    exp_wen = w ? ~wm : 8'hFF;
    exp_rd  = ref_mem[ad];
    checks++;
    if (!got || n !== 4) begin
      failures++; $display("FAIL %s latency: got %0d cycles (acked=%0b) expected 4", tag, n, got);
    end
    checks++;
    if (cen_low - c0 !== 1) begin
      failures++; $display("FAIL %s cen_low_cycles: got %0d expected 1", tag, cen_low - c0);
    end
    checks++;
    if (cap_a !== ad || cap_gwen !== ~w || cap_wen !== exp_wen) begin
      failures++;
      $display("FAIL %s issue_pins: got a=%h gwen=%b wen=%h expected a=%h gwen=%b wen=%h",
               tag, cap_a, cap_gwen, cap_wen, ad, ~w, exp_wen);
    end
    checks++;
    if ((port == 0 ? ack0_cnt - a0c : ack1_cnt - a1c) !== 1 ||
        (port == 0 ? ack1_cnt - a1c : ack0_cnt - a0c) !== 0 || both_cnt !== bc) begin
      failures++;
      $display("FAIL %s ack_pulses: got ack0=%0d ack1=%0d expected one pulse on port %0d only",
               tag, ack0_cnt - a0c, ack1_cnt - a1c, port);
    end
    if (w) begin
      checks++;
      if (cap_d !== wd) begin
        failures++; $display("FAIL %s issue_d: got %h expected %h", tag, cap_d, wd);
      end
      ref_mem[ad] = (ref_mem[ad] & ~wm) | (wd & wm);
    end else begin
      checks++;
      if (rd !== exp_rd) begin
        failures++; $display("FAIL %s rdata: got %h expected %h", tag, rd, exp_rd);
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    int c0;
    rst = 1'b1;
    drive_port(0, 1'b0, '0, '0, '0, 1'b0);
    drive_port(1, 1'b0, '0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cen !== 1'b1 || gwen !== 1'b1 || wen !== 8'hFF || a !== 9'h0 || d !== 8'h0) begin
      failures++;
      $display("FAIL reset_pins: got cen=%b gwen=%b wen=%h a=%h d=%h expected 1 1 ff 000 00",
               cen, gwen, wen, a, d);
    end
    checks++;
    if (ack0 !== 1'b0 || ack1 !== 1'b0 || rdata0 !== 8'h0 || rdata1 !== 8'h0) begin
      failures++;
      $display("FAIL reset_port_outs: got ack=%b%b rdata0=%h rdata1=%h expected 00 00 00",
               ack0, ack1, rdata0, rdata1);
    end
    @(posedge clk); c0 = cen_low;
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    checks++;
    if (cen_low - c0 !== 0) begin
      failures++; $display("FAIL reset_idle_cen: got %0d CEN-low cycles expected 0", cen_low - c0);
    end
  endtask

  task automatic test_write_read();
    access(0, 1'b1, 9'h1A5, 8'h3C, 8'hFF, "p0_write_1a5");
    access(0, 1'b0, 9'h1A5, 8'h00, 8'h00, "p0_read_1a5");
    checks++;
    if (rdata0 !== 8'h3C) begin
      failures++; $display("FAIL p0_read_value: got %h expected 3c", rdata0);
    end
  endtask

  task automatic test_bit_mask();
    access(0, 1'b1, 9'h1A5, 8'hFF, 8'hFF, "preload_1a5");
    access(1, 1'b1, 9'h1A5, 8'h00, 8'h0F, "p1_masked_write");
    checks++;
    if (cap_wen !== 8'hF0) begin
      failures++; $display("FAIL mask_wen: got %h expected f0", cap_wen);
    end
    access(1, 1'b0, 9'h1A5, 8'h00, 8'h00, "p1_read_masked");
    checks++;
    if (rdata1 !== 8'hF0) begin
      failures++; $display("FAIL mask_read_value: got %h expected f0", rdata1);
    end
  endtask

  task automatic test_input_change();
    int n;
    logic got;
    logic [7:0] rd;
    access(0, 1'b1, 9'h010, 8'h55, 8'hFF, "preload_010");
    access(0, 1'b1, 9'h011, 8'hAA, 8'hFF, "preload_011");
    @(posedge clk);
    #1 drive_port(0, 1'b0, 9'h010, 8'h00, 8'h00, 1'b1);
    @(posedge clk);
    #1 drive_port(0, 1'b1, 9'h011, 8'h00, 8'hFF, 1'b1);
    got = 1'b0; rd = '0;
    for (n = 2; n <= 20; n++) begin
      @(negedge clk);
      if (ack0) begin got = 1'b1; rd = rdata0; break; end
    end
    @(posedge clk);
    #1 drive_port(0, 1'b0, 9'h010, 8'h00, 8'h00, 1'b0);
    checks++;
    if (!got || cap_a !== 9'h010 || cap_gwen !== 1'b1) begin
      failures++;
      $display("FAIL change_issue_pins: got a=%h gwen=%b acked=%b expected a=010 gwen=1 acked=1",
               cap_a, cap_gwen, got);
    end
    checks++;
    if (rd !== 8'h55) begin
      failures++; $display("FAIL change_rdata: got %h expected 55", rd);
    end
    access(0, 1'b0, 9'h011, 8'h00, 8'h00, "change_no_write_011");
  endtask

  task automatic test_tie();
    int seq [4];
    int k, n, bc;
    logic [7:0] rd [4];
    logic [7:0] exp_rd;
    pulse_reset();
    bc = both_cnt;
    @(posedge clk);
    #1 begin
      drive_port(0, 1'b0, 9'h1A5, 8'h00, 8'h00, 1'b1);
      drive_port(1, 1'b0, 9'h010, 8'h00, 8'h00, 1'b1);
    end
    k = 0;
    for (n = 0; n < 40 && k < 4; n++) begin
      @(negedge clk);
      if (ack0) begin seq[k] = 0; rd[k] = rdata0; k++; end
      else if (ack1) begin seq[k] = 1; rd[k] = rdata1; k++; end
    end
    @(posedge clk);
    #1 begin req0 = 1'b0; req1 = 1'b0; end
    checks++;
    if (k !== 4) begin
      failures++; $display("FAIL tie_count: got %0d grants expected 4", k);
    end
    for (int i = 0; i < k; i++) begin
`ifdef SRAM_ARB_RR_EN
      int exp_port = i % 2;
`else
      int exp_port = 0;
`endif
      exp_rd = (exp_port == 0) ? ref_mem[9'h1A5] : ref_mem[9'h010];
      checks++;
      if (seq[i] !== exp_port || rd[i] !== exp_rd) begin
        failures++;
        $display("FAIL tie_grant_%0d: got port %0d data %h expected port %0d data %h",
                 i, seq[i], rd[i], exp_port, exp_rd);
      end
    end
    checks++;
    if (both_cnt !== bc) begin
      failures++; $display("FAIL tie_both_acks: got %0d expected 0", both_cnt - bc);
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_reset_in_capt();
    int a1c;
    access(1, 1'b0, 9'h1A5, 8'h00, 8'h00, "p1_read_before_reset");
    @(posedge clk);
    a1c = ack1_cnt;
    #1 drive_port(1, 1'b0, 9'h1A5, 8'h00, 8'h00, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 begin rst = 1'b1; req1 = 1'b0; end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    checks++;
    if (ack1_cnt - a1c !== 0) begin
      failures++; $display("FAIL rst_capt_ack1: got %0d pulses expected 0", ack1_cnt - a1c);
    end
    @(negedge clk);
    checks++;
    if (rdata1 !== 8'h00) begin
      failures++; $display("FAIL rst_capt_rdata1: got %h expected 00", rdata1);
    end
    access(1, 1'b0, 9'h1A5, 8'h00, 8'h00, "p1_read_after_reset");
  endtask

  task automatic test_random();
    logic [8:0] pool [6];
    pool[0] = 9'h1A5; pool[1] = 9'h010; pool[2] = 9'h011;
    pool[3] = 9'h000; pool[4] = 9'h1FF; pool[5] = 9'h0AA;
    for (int i = 0; i < 6; i++)
      access(i % 2, 1'b1, pool[i], 8'($urandom), 8'hFF, "rand_init");
    for (int i = 0; i < 24; i++)
      access(int'($urandom_range(0, 1)), 1'($urandom), pool[$urandom_range(0, 5)],
             8'($urandom), 8'($urandom), "rand_access");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_read();
    test_bit_mask();
    test_input_change();
    test_tie();
    test_reset_in_capt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
